// File: rtl/rename_regfile.sv
// Architectural register file plus register-status (rename) table for the Tomasulo core.
// Source lookups are registered and presented one cycle after the request with a done pulse.
module rename_regfile #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int TAG_W = 4,
    parameter int ID_W  = 4,
    parameter int NSRC  = 2,
    localparam int RW   = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   flush,
    input  logic                   commit_valid,
    input  logic [RW-1:0]          commit_dest,
    input  logic [XLEN-1:0]        commit_value,
    input  logic [TAG_W-1:0]       commit_tag,
    input  logic                   req_valid,
    input  logic [ID_W-1:0]        req_id,
    input  logic [NSRC-1:0]        src_valid,
    input  logic [NSRC*RW-1:0]     src_reg,
    input  logic                   rd_valid,
    input  logic [RW-1:0]          rd_reg,
    input  logic [TAG_W-1:0]       rd_tag,
    output logic                   done,
    output logic [ID_W-1:0]        done_id,
    output logic [NSRC-1:0]        src_busy,
    output logic [NSRC*TAG_W-1:0]  src_tag,
    output logic [NSRC*XLEN-1:0]   src_value
);

    logic [XLEN-1:0]       value_r [NREG];
    logic [TAG_W-1:0]      tag_r   [NREG];
    logic [NREG-1:0]       busy_r;

    logic                  accept_s;
    logic [RW-1:0]         lk_reg_s;
    logic [NSRC-1:0]       lk_busy_s;
    logic [NSRC*TAG_W-1:0] lk_tag_s;
    logic [NSRC*XLEN-1:0]  lk_value_s;

    // A flush drops any request presented in the same cycle.
    assign accept_s = req_valid && !flush;

    // Per-source lookup against the pre-rename mapping, with same-cycle commit bypass.
    always_comb begin
        lk_reg_s   = '0;
        lk_busy_s  = '0;
        lk_tag_s   = '0;
        lk_value_s = '0;
        for (int k = 0; k < NSRC; k++) begin
            lk_reg_s = src_reg[k*RW +: RW];
            if (!(req_valid && src_valid[k]) || (lk_reg_s == '0)) begin
                lk_busy_s[k] = 1'b0;
            end else if (!busy_r[lk_reg_s]) begin
                lk_value_s[k*XLEN +: XLEN] = value_r[lk_reg_s];
            end else if (commit_valid && (commit_dest == lk_reg_s) &&
                         (commit_tag == tag_r[lk_reg_s])) begin
                lk_value_s[k*XLEN +: XLEN] = commit_value;
            end else begin
                lk_busy_s[k]                = 1'b1;
                lk_tag_s[k*TAG_W +: TAG_W]  = tag_r[lk_reg_s];
            end
        end
    end

    // Register file and status table: commit first, then rename overrides, flush clears busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= '0;
            for (int i = 0; i < NREG; i++) begin
                value_r[i] <= '0;
                tag_r[i]   <= '0;
            end
        end else if (rdy) begin
            if (commit_valid && (commit_dest != '0)) begin
                value_r[commit_dest] <= commit_value;
                if (busy_r[commit_dest] && (tag_r[commit_dest] == commit_tag)) begin
                    busy_r[commit_dest] <= 1'b0;
                end
            end
            if (accept_s && rd_valid && (rd_reg != '0)) begin
                busy_r[rd_reg] <= 1'b1;
                tag_r[rd_reg]  <= rd_tag;
            end
            if (flush) begin
                busy_r <= '0;
            end
        end
    end

    // Registered lookup results; payload is only meaningful while done is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done      <= 1'b0;
            done_id   <= '0;
            src_busy  <= '0;
            src_tag   <= '0;
            src_value <= '0;
        end else if (rdy) begin
            done <= accept_s;
            if (accept_s) begin
                done_id   <= req_id;
                src_busy  <= lk_busy_s;
                src_tag   <= lk_tag_s;
                src_value <= lk_value_s;
            end
        end
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: array-based reference model checked every cycle,
// plus literal expectations taken from the hand-worked scenarios.
module tb_rename_regfile;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        commit_valid;
    logic [4:0]  commit_dest;
    logic [31:0] commit_value;
    logic [3:0]  commit_tag;
    logic        req_valid;
    logic [3:0]  req_id;
    logic [1:0]  src_valid;
    logic [9:0]  src_reg;
    logic        rd_valid;
    logic [4:0]  rd_reg;
    logic [3:0]  rd_tag;
    logic        done;
    logic [3:0]  done_id;
    logic [1:0]  src_busy;
    logic [7:0]  src_tag;
    logic [63:0] src_value;

    rename_regfile dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .commit_valid(commit_valid), .commit_dest(commit_dest),
        .commit_value(commit_value), .commit_tag(commit_tag),
        .req_valid(req_valid), .req_id(req_id), .src_valid(src_valid),
        .src_reg(src_reg), .rd_valid(rd_valid), .rd_reg(rd_reg), .rd_tag(rd_tag),
        .done(done), .done_id(done_id), .src_busy(src_busy),
        .src_tag(src_tag), .src_value(src_value)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [31:0] mval  [32];
    logic [3:0]  mtag  [32];
    logic        mbusy [32];
    logic        e_done;
    logic [3:0]  e_id;
    logic [1:0]  e_busy;
    logic [7:0]  e_tag;
    logic [63:0] e_value;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mval[i] = 32'd0; mtag[i] = 4'd0; mbusy[i] = 1'b0;
        end
        e_done = 1'b0; e_id = 4'd0; e_busy = 2'd0; e_tag = 8'd0; e_value = 64'd0;
    endtask

    task automatic model_step();
        logic acc;
        logic [4:0] r;
        if (!rdy) return;
        acc = req_valid && !flush;
        if (acc) begin
            e_id = req_id; e_busy = 2'd0; e_tag = 8'd0; e_value = 64'd0;
            for (int k = 0; k < 2; k++) begin
                r = src_reg[k*5 +: 5];
                if (src_valid[k] && r != 5'd0) begin
                    if (!mbusy[r])
                        e_value[k*32 +: 32] = mval[r];
                    else if (commit_valid && commit_dest == r && commit_tag == mtag[r])
                        e_value[k*32 +: 32] = commit_value;
                    else begin
                        e_busy[k] = 1'b1;
                        e_tag[k*4 +: 4] = mtag[r];
                    end
                end
            end
        end
        e_done = acc;
        if (commit_valid && commit_dest != 5'd0) begin
            mval[commit_dest] = commit_value;
            if (mbusy[commit_dest] && mtag[commit_dest] == commit_tag) mbusy[commit_dest] = 1'b0;
        end
        if (acc && rd_valid && rd_reg != 5'd0) begin
            mbusy[rd_reg] = 1'b1;
            mtag[rd_reg]  = rd_tag;
        end
        if (flush) for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
    endtask

    task automatic compare();
        chk("done", {63'd0, done}, {63'd0, e_done});
        if (e_done) begin
            chk("done_id",   {60'd0, done_id},  {60'd0, e_id});
            chk("src_busy",  {62'd0, src_busy}, {62'd0, e_busy});
            chk("src_tag",   {56'd0, src_tag},  {56'd0, e_tag});
            chk("src_value", src_value, e_value);
        end
    endtask

    task automatic clear();
        flush = 1'b0; commit_valid = 1'b0; commit_dest = 5'd0; commit_value = 32'd0;
        commit_tag = 4'd0; req_valid = 1'b0; req_id = 4'd0; src_valid = 2'd0;
        src_reg = 10'd0; rd_valid = 1'b0; rd_reg = 5'd0; rd_tag = 4'd0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare();
        clear();
    endtask

    task automatic lookup(input logic [3:0] id, input logic [1:0] sv,
                          input logic [4:0] s0, input logic [4:0] s1);
        req_valid = 1'b1; req_id = id; src_valid = sv; src_reg = {s1, s0};
    endtask

    task automatic rename(input logic [4:0] rd, input logic [3:0] t);
        req_valid = 1'b1; rd_valid = 1'b1; rd_reg = rd; rd_tag = t;
    endtask

    task automatic commit(input logic [4:0] d, input logic [3:0] t, input logic [31:0] v);
        commit_valid = 1'b1; commit_dest = d; commit_tag = t; commit_value = v;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1;
        clear();
        model_reset();
        #12;
        chk("rst_done",  {63'd0, done}, 64'd0);
        chk("rst_value", src_value, 64'd0);
        rst = 1'b1;

        // plain lookup of unwritten registers
        lookup(4'd1, 2'b11, 5'd5, 5'd6); step();
        chk("lk_done", {63'd0, done}, 64'd1);
        chk("lk_busy", {62'd0, src_busy}, 64'd0);
        step();
        chk("lk_done_drop", {63'd0, done}, 64'd0);

        // rename then bypassed commit
        rename(5'd3, 4'd7); lookup(4'd2, 2'b00, 5'd0, 5'd0); step();
        lookup(4'd3, 2'b01, 5'd3, 5'd0); step();
        chk("x3_busy", {62'd0, src_busy}, 64'd1);
        chk("x3_tag",  {60'd0, src_tag[3:0]}, 64'd7);
        lookup(4'd4, 2'b01, 5'd3, 5'd0); commit(5'd3, 4'd7, 32'hDEADBEEF); step();
        chk("x3_bypass_busy", {62'd0, src_busy}, 64'd0);
        chk("x3_bypass_val",  {32'd0, src_value[31:0]}, 64'hDEADBEEF);
        lookup(4'd5, 2'b11, 5'd3, 5'd0); step();
        chk("x3_later_val", src_value, 64'h00000000DEADBEEF);

        // stale commit leaves newer rename busy
        rename(5'd4, 4'd2); step();
        rename(5'd4, 4'd9); step();
        commit(5'd4, 4'd2, 32'h11); step();
        lookup(4'd6, 2'b01, 5'd4, 5'd0); step();
        chk("x4_stale_busy", {62'd0, src_busy}, 64'd1);
        chk("x4_stale_tag",  {60'd0, src_tag[3:0]}, 64'd9);

        // flush with a same-cycle request
        rename(5'd1, 4'd1); step();
        rename(5'd2, 4'd2); step();
        rename(5'd10, 4'd3); lookup(4'd9, 2'b11, 5'd1, 5'd2); flush = 1'b1; step();
        chk("flush_no_done", {63'd0, done}, 64'd0);
        lookup(4'd10, 2'b11, 5'd1, 5'd2); step();
        chk("flush_busy12", {62'd0, src_busy}, 64'd0);
        lookup(4'd11, 2'b11, 5'd10, 5'd4); step();
        chk("flush_busy10", {62'd0, src_busy}, 64'd0);
        chk("x4_value", {32'd0, src_value[63:32]}, 64'h11);

        // rename and matching commit on the same register: rename wins
        rename(5'd8, 4'd1); step();
        rename(5'd8, 4'd5); commit(5'd8, 4'd1, 32'h22); step();
        lookup(4'd12, 2'b01, 5'd8, 5'd0); step();
        chk("x8_busy", {62'd0, src_busy}, 64'd1);
        chk("x8_tag",  {60'd0, src_tag[3:0]}, 64'd5);
        commit(5'd8, 4'd5, 32'h33); step();
        lookup(4'd13, 2'b01, 5'd8, 5'd0); step();
        chk("x8_val", src_value, 64'h33);

        // x0 never renamed
        rename(5'd0, 4'd3); step();
        lookup(4'd14, 2'b01, 5'd0, 5'd0); step();
        chk("x0_val", {62'd0, src_busy} | src_value, 64'd0);
        step();

        // freeze with rdy low
        for (int i = 0; i < 3; i++) begin
            rdy = 1'b0; rename(5'd12, 4'd4); lookup(4'd15, 2'b11, 5'd8, 5'd12); step();
            chk("frz_done", {63'd0, done}, 64'd0);
        end
        rdy = 1'b1;
        lookup(4'd1, 2'b01, 5'd12, 5'd0); step();
        chk("frz_state", {62'd0, src_busy}, 64'd0);

        // asynchronous reset in the middle of a request cycle
        lookup(4'd2, 2'b01, 5'd8, 5'd0); step();
        chk("pre_rst_done", {63'd0, done}, 64'd1);
        lookup(4'd3, 2'b01, 5'd8, 5'd0);
        #2 rst = 1'b0;
        #1;
        chk("arst_done",  {63'd0, done}, 64'd0);
        chk("arst_id",    {60'd0, done_id}, 64'd0);
        chk("arst_value", src_value, 64'd0);
        model_reset();
        clear();
        #2 rst = 1'b1;
        lookup(4'd4, 2'b11, 5'd8, 5'd3); step();
        chk("post_rst_val", src_value, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Parametrised architectural register file plus register status (rename) table for the Tomasulo core.
- Sits between the decoder/RS dispatch path, the CDB commit broadcast and the predictor flush.
- Supports NSRC source lookups per rename request and an optional destination (rd_valid).
- Provides a same-cycle commit bypass into source lookups, x0 hardwired to zero, and a defined result for unused sources.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (power of 2); RW = log2(NREG)
TAG_W, 4, ROB/rename tag width
ID_W, 4, request id width
NSRC, 2, source operands looked up per request

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
rdy  in  1  global ready; low = freeze all state and outputs
flush  in  1  predictor mispredict flush
commit_valid  in  1  CDB/ROB commit strobe
commit_dest  in  RW  committed destination register
commit_value  in  XLEN  committed value
commit_tag  in  TAG_W  rename tag of committing instruction
req_valid  in  1  rename/lookup request
req_id  in  ID_W  request id, echoed back
src_valid  in  NSRC  per-source lookup enable
src_reg  in  NSRC*RW  packed source register indices, source k at [k*RW +: RW]
rd_valid  in  1  request writes a destination
rd_reg  in  RW  destination register
rd_tag  in  TAG_W  new rename tag for rd_reg
done  out  1  one-cycle pulse, lookup results valid
done_id  out  ID_W  echoed req_id
src_busy  out  NSRC  source k still pending
src_tag  out  NSRC*TAG_W  producer tag when busy
src_value  out  NSRC*XLEN  value when not busy

Behaviour:
- Reset (rst=0, asynchronous):
  - All value[i], busy[i] and tag[i] are set to 0.
  - All outputs are set to 0.
- rdy=0: no state or output changes; inputs are ignored that cycle.
- Latency: a request sampled at edge N presents results after edge N with done=1 for exactly one cycle. Without a new accepted request, done=0 next cycle. There is no backpressure; one request per cycle is allowed.
- Commit (commit_valid=1, commit_dest!=0):
  - value[dest] <= commit_value, unconditionally.
  - busy[dest] <= 0 only if busy[dest]=1 and tag[dest]==commit_tag. A stale commit leaves the newer rename busy.
- Source lookup k (req_valid && src_valid[k]):
  - src_reg==0: busy 0, value 0.
  - Otherwise, if busy[r]=0: busy 0, value=value[r].
  - Otherwise, if a same-cycle commit has dest==r and tag==tag[r]: busy 0, value=commit_value (bypass).
  - Otherwise: busy 1, tag=tag[r]; src_value is don't-care, and the RTL drives 0.
- Unused source (src_valid[k]=0): busy 0, tag 0, value 0.
- Lookups see the mapping from before this request's own rd rename, so an instruction reading its own rd gets the old producer.
- Rename (req_valid && rd_valid && rd_reg!=0): busy[rd] <= 1, tag[rd] <= rd_tag.
  - If it hits the same register as a same-cycle matching commit, the rename wins: busy stays 1 with the new tag, and the value is still written.
- Flush:
  - All busy cleared; done <= 0.
  - A request in the same cycle is dropped: no rename installed, no done.
  - A same-cycle commit still writes its value.
- Register 0 is never written and is never busy.

Test Plan:
- Reset, then request src=(5,6), no rd -> next cycle done=1, busy=00, values 0/0; following cycle done=0.
- Rename rd=3 tag=7; next request src0=3 -> busy=1, tag=7. Then commit dest=3 tag=7 value=0xDEADBEEF with the same-cycle lookup of 3 -> busy=0, value=0xDEADBEEF (bypass); a later lookup also returns 0xDEADBEEF, not busy.
- Rename x4 tag=2, then x4 tag=9. Commit dest=4 tag=2 value=0x11 -> x4 remains busy with tag 9, and value[4]=0x11.
- Same cycle: rename x8 tag=5 and commit dest=8 tag=(current tag of x8) value=0x22 -> x8 is busy with tag 5; after commit tag 5 value=0x33 the lookup returns 0x33.
- With x1 and x2 busy, assert flush together with req_valid (rd=10) -> no done pulse; lookups of 1, 2 and 10 afterwards are not busy.
- Rename rd=0 tag=3, then lookup src=0 -> busy=0, value=0. Hold rdy=0 for 3 cycles with req_valid=1 -> no done, state unchanged.
- Pull rst low mid-request -> outputs are 0 immediately, without a clock edge.
